// File: rtl/vfifo_tdp_ram_be.sv
// -----------------------------------------------------------------------------
// vfifo_tdp_ram_be
//
// True dual-port RAM with per-byte write enables. Both ports share a single
// clock. After reset, a clear sweep fills every location with INIT_VALUE.
// The memory is unavailable to users while the sweep runs.
//
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   ADDR_WIDTH : address width; depth = 2**ADDR_WIDTH words
//   RDW_MODE   : read-during-write result. 0 = old data, 1 = new (merged) data
//   INIT_VALUE : word written to every location by the clear sweep
//
// Ports
//   clk        : clock; all logic runs on its rising edge
//   rst        : synchronous active-high reset (restarts the clear sweep)
//   init_busy  : high while the clear sweep runs
//   adr_a/b    : port addresses
//   d_a/b      : write data
//   we_a/b     : write enables
//   be_a/b     : byte enables; bit i covers data bits 8i+7:8i
//   re_a/b     : read enables
//   q_a/b      : registered read data
//
// Configuration
//   VFIFO_TDP_RAM_OUTPUT_REG_EN : when defined, a second, free-running output
//                                 register follows each q. Read latency is
//                                 then 2 instead of 1.
// -----------------------------------------------------------------------------
module vfifo_tdp_ram_be #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_busy,
    input  logic [ADDR_WIDTH-1:0]   adr_a,
    input  logic [ADDR_WIDTH-1:0]   adr_b,
    input  logic [DATA_WIDTH-1:0]   d_a,
    input  logic [DATA_WIDTH-1:0]   d_b,
    input  logic                    we_a,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic                    re_a,
    input  logic                    re_b,
    output logic [DATA_WIDTH-1:0]   q_a,
    output logic [DATA_WIDTH-1:0]   q_b
);

    localparam int DEPTH     = 2**ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    localparam logic STATE_CLEAR = 1'b0;
    localparam logic STATE_READY = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic                  state;
    logic [ADDR_WIDTH-1:0] cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_a;
    logic                  wr_b;
    logic                  rd_a;
    logic                  rd_b;
    logic [DATA_WIDTH-1:0] rd_word_a;
    logic [DATA_WIDTH-1:0] rd_word_b;
    logic [DATA_WIDTH-1:0] q_a_s1;
    logic [DATA_WIDTH-1:0] q_b_s1;

    // -------------------------------------------------------------------------
    // Clear sweep FSM. The counter stops at the last address instead of
    // wrapping, so the sweep takes exactly DEPTH cycles.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, whatever the evaluation order of blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_CLEAR;
            cnt   <= '0;
        end else if (state == STATE_CLEAR) begin
            if (cnt == LAST_ADDR) begin
                state <= STATE_READY;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign init_busy = (state == STATE_CLEAR);

    assign wr_a = we_a & ~init_busy;
    assign wr_b = we_b & ~init_busy;
    assign rd_a = re_a & ~init_busy;
    assign rd_b = re_b & ~init_busy;

    // -------------------------------------------------------------------------
    // Memory array. Port B bytes are assigned first and port A bytes second.
    // Because the last non-blocking assignment wins, port A has priority on
    // any byte that both ports enable at the same address.
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch. This keeps it mappable to block RAM.
    // Contents are defined by the clear sweep, not by rst.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            if (!rst) begin
                mem[cnt] <= INIT_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_b && be_b[i]) begin
                    mem[adr_b][8*i +: 8] <= d_b[8*i +: 8];
                end
            end
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_a && be_a[i]) begin
                    mem[adr_a][8*i +: 8] <= d_a[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read word selection. In new-data mode, this cycle's writes from both
    // ports are overlaid on the stored word. B is overlaid first, then A, so
    // the forwarded word matches what the array will hold after the edge.
    // -------------------------------------------------------------------------
    // NOTE: each output is given a default first, so no latch is inferred
    // on paths where no overlay applies.
    always_comb begin
        rd_word_a = mem[adr_a];
        rd_word_b = mem[adr_b];
        if (RDW_MODE == 1) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_b && be_b[i] && (adr_b == adr_a)) rd_word_a[8*i +: 8] = d_b[8*i +: 8];
                if (wr_b && be_b[i])                     rd_word_b[8*i +: 8] = d_b[8*i +: 8];
            end
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_a && be_a[i])                     rd_word_a[8*i +: 8] = d_a[8*i +: 8];
                if (wr_a && be_a[i] && (adr_a == adr_b)) rd_word_b[8*i +: 8] = d_a[8*i +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // First output stage. It is held at zero during reset and the clear sweep.
    // Otherwise it loads only on a read and holds its value when re is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || init_busy) begin
            q_a_s1 <= '0;
            q_b_s1 <= '0;
        end else begin
            if (rd_a) q_a_s1 <= rd_word_a;
            if (rd_b) q_b_s1 <= rd_word_b;
        end
    end

`ifdef VFIFO_TDP_RAM_OUTPUT_REG_EN
    // Second output stage. It advances every cycle, so the hold behaviour of
    // the first stage shows up one cycle later.
    logic [DATA_WIDTH-1:0] q_a_s2;
    logic [DATA_WIDTH-1:0] q_b_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a_s2 <= '0;
            q_b_s2 <= '0;
        end else begin
            q_a_s2 <= q_a_s1;
            q_b_s2 <= q_b_s1;
        end
    end

    assign q_a = q_a_s2;
    assign q_b = q_b_s2;
`else
    assign q_a = q_a_s1;
    assign q_b = q_b_s1;
`endif

endmodule

// File: tb/tb_vfifo_tdp_ram_be.sv
// -----------------------------------------------------------------------------
// tb_vfifo_tdp_ram_be
//
// Directed bench for vfifo_tdp_ram_be. It instantiates two copies of the
// design, one in old-data mode (RDW_MODE=0) and one in new-data mode
// (RDW_MODE=1). Both copies are driven with identical stimulus.
// Geometry: 32-bit words, 16 locations, INIT_VALUE 32'hA5A5A5A5.
// -----------------------------------------------------------------------------
module tb_vfifo_tdp_ram_be;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [DW-1:0] INIT = 32'hA5A5A5A5;

`ifdef VFIFO_TDP_RAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] adr_a, adr_b;
    logic [DW-1:0] d_a, d_b;
    logic          we_a, we_b, re_a, re_b;
    logic [3:0]    be_a, be_b;
    logic          busy0, busy1;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;

    int n_checks = 0;
    int n_fails  = 0;
    int cycles;

    vfifo_tdp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .INIT_VALUE(INIT)) dut_old (
        .clk(clk), .rst(rst), .init_busy(busy0),
        .adr_a(adr_a), .adr_b(adr_b), .d_a(d_a), .d_b(d_b),
        .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
        .re_a(re_a), .re_b(re_b), .q_a(q_a0), .q_b(q_b0)
    );

    vfifo_tdp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .INIT_VALUE(INIT)) dut_new (
        .clk(clk), .rst(rst), .init_busy(busy1),
        .adr_a(adr_a), .adr_b(adr_b), .d_a(d_a), .d_b(d_b),
        .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
        .re_a(re_a), .re_b(re_b), .q_a(q_a1), .q_b(q_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
        be_a = 4'h0; be_b = 4'h0;
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        adr_a = a; d_a = d; be_a = be; we_a = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_a(input logic [AW-1:0] a);
        adr_a = a; re_a = 1'b1;
        tick();
        re_a = 1'b0;
        repeat (LAT-1) tick();
    endtask

    task automatic read_b(input logic [AW-1:0] a);
        adr_b = a; re_b = 1'b1;
        tick();
        re_b = 1'b0;
        repeat (LAT-1) tick();
    endtask

    // Count edges until init_busy falls. The loop is bounded so a stuck
    // sweep still reaches the summary line.
    task automatic wait_sweep(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (!busy0) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        adr_a = '0; adr_b = '0; d_a = '0; d_b = '0;
        idle();
        tick();
        tick();
        check("reset_busy", {31'b0, busy0}, 32'h1);
        check("reset_q_a", q_a0, 32'h0);
        check("reset_q_b", q_b0, 32'h0);

        // Release reset with user traffic applied; it must be ignored.
        adr_a = 4'd9; d_a = 32'h0; be_a = 4'hF; we_a = 1'b1; re_a = 1'b1;
        rst = 1'b0;
        wait_sweep(cycles);
        idle();
        check("sweep_cycles", cycles, 32'd16);
        check("sweep_busy_new", {31'b0, busy1}, 32'h0);
        check("sweep_q_a_held", q_a0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            read_a(i[AW-1:0]);
            check($sformatf("init_rd_%0d", i), q_a0, INIT);
        end

        // Partial byte write on A, then read on B.
        write_a(4'd3, 32'h11223344, 4'b0101);
        read_b(4'd3);
        check("be_write_b_rd", q_b0, 32'hA522A544);

        // Latency: q_a holds INIT from the last read of address 15.
        adr_a = 4'd3; re_a = 1'b1;
        tick();
        re_a = 1'b0;
        check("latency_edge1", q_a0, (LAT == 1) ? 32'hA522A544 : INIT);
        repeat (LAT-1) tick();
        check("latency_final", q_a0, 32'hA522A544);
        adr_a = 4'd0;
        repeat (3) tick();
        check("hold_q_a", q_a0, 32'hA522A544);

        // Collision at address 5: A bytes win, B fills the rest.
        adr_a = 4'd5; d_a = 32'hFFFFFFFF; be_a = 4'b0011; we_a = 1'b1;
        adr_b = 4'd5; d_b = 32'h00000000; be_b = 4'b1111; we_b = 1'b1;
        tick();
        idle();
        read_a(4'd5);
        check("collide_5", q_a0, 32'h0000FFFF);

        // Read during write, cross-port.
        write_a(4'd7, 32'h0, 4'hF);
        adr_a = 4'd7; d_a = 32'hDEADBEEF; be_a = 4'hF; we_a = 1'b1;
        adr_b = 4'd7; re_b = 1'b1;
        tick();
        idle();
        repeat (LAT-1) tick();
        check("rdw_old_q_b", q_b0, 32'h0);
        check("rdw_new_q_b", q_b1, 32'hDEADBEEF);
        read_b(4'd7);
        check("rdw_stored", q_b0, 32'hDEADBEEF);

        // New-data mode merges both ports' bytes into A's read.
        adr_a = 4'd7; d_a = 32'h11111111; be_a = 4'b0001; we_a = 1'b1; re_a = 1'b1;
        adr_b = 4'd7; d_b = 32'h22222222; be_b = 4'b1000; we_b = 1'b1;
        tick();
        idle();
        repeat (LAT-1) tick();
        check("merge_old_q_a", q_a0, 32'hDEADBEEF);
        check("merge_new_q_a", q_a1, 32'h22ADBE11);
        read_a(4'd7);
        check("merge_stored", q_a0, 32'h22ADBE11);

        // Reset mid-sweep restarts the sweep.
        write_a(4'd2, 32'h1, 4'hF);
        read_a(4'd2);
        check("pre_rst_addr2", q_a0, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("mid_sweep_busy", {31'b0, busy0}, 32'h1);
        rst = 1'b1;
        tick();
        check("rst_mid_busy", {31'b0, busy0}, 32'h1);
        check("rst_mid_q_a", q_a0, 32'h0);
        rst = 1'b0;
        wait_sweep(cycles);
        check("resweep_cycles", cycles, 32'd16);
        read_a(4'd2);
        check("resweep_addr2", q_a0, INIT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/vfifo_tdp_ram_be.md
VFIFO_TDP_RAM_BE -- requirements
Module: vfifo_tdp_ram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RDW_MODE, default 0, read-during-write result: 0 = old data, 1 = new (merged) data.
REQ-004 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit word written to every location by the clear sweep.
REQ-005 SHALL have port clk, input, 1 bit: single clock for both ports; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port init_busy, output, 1 bit: high while the clear sweep runs.
REQ-008 SHALL have ports adr_a, adr_b, input, ADDR_WIDTH bits each: port addresses.
REQ-009 SHALL have ports d_a, d_b, input, DATA_WIDTH bits each: write data.
REQ-010 SHALL have ports we_a, we_b, input, 1 bit each: write enables.
REQ-011 SHALL have ports be_a, be_b, input, DATA_WIDTH/8 bits each: byte enables; bit i covers data bits 8i+7:8i.
REQ-012 SHALL have ports re_a, re_b, input, 1 bit each: read enables.
REQ-013 SHALL have ports q_a, q_b, output, DATA_WIDTH bits each: registered read data.

Function
REQ-014 A port write SHALL occur on a rising edge when we_x=1 and init_busy=0, updating only bytes with be_x=1.
REQ-015 A port read SHALL occur on a rising edge when re_x=1 and init_busy=0; q_x SHALL show ram[adr_x] one cycle later (latency 1).
REQ-016 When re_x=0, q_x SHALL hold its previous value.
REQ-017 RDW_MODE=0: a read of an address written in the same cycle, by either port, SHALL return the pre-write word.
REQ-018 RDW_MODE=1: such a read SHALL return the post-write word, including bytes written by the other port (bypass forwarding).
REQ-019 Both ports writing the same address in one cycle: bytes enabled on A SHALL take d_a; bytes enabled only on B SHALL take d_b.
REQ-020 The clear FSM SHALL have two states: CLEAR and READY.
REQ-021 In CLEAR, each cycle SHALL write INIT_VALUE at sweep counter address cnt, then increment cnt.
REQ-022 At cnt = 2**ADDR_WIDTH-1, CLEAR SHALL write that last location and transition to READY.
REQ-023 READY SHALL persist until rst.
REQ-024 The sweep SHALL take exactly 2**ADDR_WIDTH cycles after rst deasserts.
REQ-025 init_busy SHALL be 1 exactly when the FSM is in CLEAR.
REQ-026 During CLEAR, user we/re SHALL be ignored and q_a/q_b SHALL hold 0.
REQ-027 Address arithmetic SHALL be modulo 2**ADDR_WIDTH; the sweep counter SHALL NOT wrap past the last address.

Reset
REQ-028 rst=1 at an edge SHALL force FSM=CLEAR, cnt=0, q_a=0, q_b=0, and all output pipeline registers to 0.
REQ-029 rst asserted mid-sweep SHALL restart the sweep from address 0.
REQ-030 rst SHALL NOT itself clear memory contents; only the sweep does.

Configuration
REQ-031 With macro VFIFO_TDP_RAM_OUTPUT_REG_EN defined, a second register stage SHALL follow each q_x, making read latency 2.
REQ-032 With the macro defined, the second stage SHALL advance every cycle, so q_x shows the first-stage value delayed one cycle (hold behaviour delayed accordingly).
REQ-033 Without the macro, read latency SHALL be 1 and no extra stage SHALL exist.

Verification (bench: DATA_WIDTH=32, ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5)
REQ-034 Release rst -> init_busy high 16 cycles then low; read every address -> 32'hA5A5A5A5.
REQ-035 A writes 32'h11223344 at 3 with be_a=4'b0101; B reads 3 next cycle -> 32'hA522A544.
REQ-036 A writes d_a=32'hFFFFFFFF (be_a=4'b0011) and B writes d_b=32'h00000000 (be_b=4'b1111) to address 5 in the same cycle; read 5 -> 32'h0000FFFF.
REQ-037 RDW_MODE=0 vs 1: addr 7 holds 32'h0; A writes 32'hDEADBEEF while B reads 7 same cycle -> q_b = 32'h0 / 32'hDEADBEEF.
REQ-038 Assert rst at sweep cycle 8 after addr 2 was written 32'h1 pre-reset -> sweep restarts at 0, busy 16 more cycles, addr 2 reads 32'hA5A5A5A5.
REQ-039 With VFIFO_TDP_RAM_OUTPUT_REG_EN: read issued at edge N -> q valid after edge N+2; re low -> q holds.
